// File: rtl/softreg_cfg_responder.sv
// SoftReg responder for the PageRank core: captures host parameter writes, pulses start,
// answers host reads and holds a DONE_ALL read until the core finishes or the read times out.
module softreg_cfg_responder #(
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        softreg_req_valid,
  input  logic        softreg_req_isWrite,
  input  logic [31:0] softreg_req_addr,
  input  logic [63:0] softreg_req_data,
  output logic        softreg_resp_valid,
  output logic [63:0] softreg_resp_data,
  output logic [31:0] n_vert,
  output logic [31:0] n_inedges,
  output logic [63:0] vaddr,
  output logic [63:0] ieaddr,
  output logic [63:0] write_addr0,
  output logic [63:0] write_addr1,
  output logic [31:0] n_rounds,
  output logic        start,
  input  logic        core_done
);

  localparam logic [31:0] ADDR_N_VERT      = 32'd0;
  localparam logic [31:0] ADDR_N_INEDGES   = 32'd1;
  localparam logic [31:0] ADDR_VADDR       = 32'd2;
  localparam logic [31:0] ADDR_IEADDR      = 32'd3;
  localparam logic [31:0] ADDR_WA0         = 32'd4;
  localparam logic [31:0] ADDR_WA1         = 32'd5;
  localparam logic [31:0] ADDR_N_ROUNDS    = 32'd6;
  localparam logic [31:0] ADDR_DONE_PARAMS = 32'd7;
  localparam logic [31:0] ADDR_DONE_ALL    = 32'd8;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  // state  | meaning
  // CONFIG | accepting parameter writes, core idle
  // RUN    | parameters frozen, core iterating
  // DONE   | core finished; terminal until reset
  typedef enum logic [1:0] {ST_CONFIG, ST_RUN, ST_DONE} state_t;

  state_t         state_q;
  logic [31:0]    n_vert_q, n_inedges_q, n_rounds_q;
  logic [63:0]    vaddr_q, ieaddr_q, wa0_q, wa1_q;
  logic           start_q;
  logic           resp_valid_q;
  logic [63:0]    resp_data_q;
  logic           err_q;
  logic           pending_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] cnt_d;
  logic           core_done_run;
  logic           done_now;
  logic           addr_known;
  logic [63:0]    status;
  logic [63:0]    rd_data;

  always_comb begin
    cnt_d         = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    core_done_run = (state_q == ST_RUN) && core_done;
    done_now      = (state_q == ST_DONE) || core_done_run;
    addr_known    = (softreg_req_addr <= ADDR_DONE_ALL);
    status        = err_q ? 64'd0 : 64'd1;
    rd_data       = 64'd0;
    case (softreg_req_addr)
      ADDR_N_VERT:    rd_data = {32'd0, n_vert_q};
      ADDR_N_INEDGES: rd_data = {32'd0, n_inedges_q};
      ADDR_VADDR:     rd_data = vaddr_q;
      ADDR_IEADDR:    rd_data = ieaddr_q;
      ADDR_WA0:       rd_data = wa0_q;
      ADDR_WA1:       rd_data = wa1_q;
      ADDR_N_ROUNDS:  rd_data = {32'd0, n_rounds_q};
      default:        rd_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CONFIG;
      n_vert_q     <= '0;
      n_inedges_q  <= '0;
      vaddr_q      <= '0;
      ieaddr_q     <= '0;
      wa0_q        <= '0;
      wa1_q        <= '0;
      n_rounds_q   <= '0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      start_q      <= 1'b0;
      if (core_done_run) state_q <= ST_DONE;

      if (pending_q) begin
        // A held DONE_ALL read owns the port; anything else the host sends is an error.
        if (core_done_run) begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= status;
          pending_q    <= 1'b0;
        end else if (TIMEOUT != 0) begin
          cnt_q <= cnt_d;
          if (cnt_d == TO_CNT) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= 64'd0;
            pending_q    <= 1'b0;
          end
        end
        if (softreg_req_valid) err_q <= 1'b1;
      end else if (softreg_req_valid) begin
        if (softreg_req_isWrite) begin
          if (state_q != ST_CONFIG) begin
            if (addr_known) err_q <= 1'b1;
          end else begin
            case (softreg_req_addr)
              ADDR_N_VERT:      n_vert_q    <= softreg_req_data[31:0];
              ADDR_N_INEDGES:   n_inedges_q <= softreg_req_data[31:0];
              ADDR_VADDR:       vaddr_q     <= softreg_req_data;
              ADDR_IEADDR:      ieaddr_q    <= softreg_req_data;
              ADDR_WA0:         wa0_q       <= softreg_req_data;
              ADDR_WA1:         wa1_q       <= softreg_req_data;
              ADDR_N_ROUNDS:    n_rounds_q  <= softreg_req_data[31:0];
              ADDR_DONE_PARAMS: begin
                state_q <= ST_RUN;
                start_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end else if (softreg_req_addr == ADDR_DONE_ALL) begin
          if (done_now) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= status;
          end else if (TIMEOUT == 1) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= 64'd0;
          end else begin
            // The request cycle itself counts as the first pending cycle.
            pending_q <= 1'b1;
            cnt_q     <= (TIMEOUT != 0) ? CNT_W'(1) : '0;
          end
        end else begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= rd_data;
        end
      end
    end
  end

  assign softreg_resp_valid = resp_valid_q;
  assign softreg_resp_data  = resp_data_q;
  assign n_vert             = n_vert_q;
  assign n_inedges          = n_inedges_q;
  assign vaddr              = vaddr_q;
  assign ieaddr             = ieaddr_q;
  assign write_addr0        = wa0_q;
  assign write_addr1        = wa1_q;
  assign n_rounds           = n_rounds_q;
  assign start              = start_q;

endmodule

// File: tb/tb_softreg_cfg_responder.sv
// Bench for softreg_cfg_responder: two instances (no timeout / TIMEOUT=50) share one stimulus
// stream and are checked against a register-array model of the host-visible behaviour.
module tb_softreg_cfg_responder;

  localparam int A_N_VERT = 0, A_N_INEDGES = 1, A_VADDR = 2, A_IEADDR = 3;
  localparam int A_WA0 = 4, A_WA1 = 5, A_N_ROUNDS = 6, A_DRP = 7, A_DONE_ALL = 8;
  localparam int A_UNKNOWN = 32'hFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, core_done = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;

  logic        ra_v, rb_v, st_a, st_b;
  logic [63:0] ra_d, rb_d, va_a, va_b, ia_a, ia_b, w0_a, w0_b, w1_a, w1_b;
  logic [31:0] nv_a, nv_b, ni_a, ni_b, nr_a, nr_b;

  softreg_cfg_responder #(.TIMEOUT(0), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .softreg_req_valid(req_valid), .softreg_req_isWrite(req_wr),
    .softreg_req_addr(req_addr), .softreg_req_data(req_data),
    .softreg_resp_valid(ra_v), .softreg_resp_data(ra_d),
    .n_vert(nv_a), .n_inedges(ni_a), .vaddr(va_a), .ieaddr(ia_a),
    .write_addr0(w0_a), .write_addr1(w1_a), .n_rounds(nr_a), .start(st_a),
    .core_done(core_done));

  softreg_cfg_responder #(.TIMEOUT(50), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .softreg_req_valid(req_valid), .softreg_req_isWrite(req_wr),
    .softreg_req_addr(req_addr), .softreg_req_data(req_data),
    .softreg_resp_valid(rb_v), .softreg_resp_data(rb_d),
    .n_vert(nv_b), .n_inedges(ni_b), .vaddr(va_b), .ieaddr(ia_b),
    .write_addr0(w0_b), .write_addr1(w1_b), .n_rounds(nr_b), .start(st_b),
    .core_done(core_done));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: the seven parameter registers as seen by the host, sticky error, phase.
  logic [63:0] m_reg [7];
  bit          m_err;
  int          m_phase;

  function automatic bit narrow(input int i);
    return (i == A_N_VERT) || (i == A_N_INEDGES) || (i == A_N_ROUNDS);
  endfunction

  function automatic logic [63:0] outv(input bit b, input int idx);
    case (idx)
      0: return b ? {32'd0, nv_b} : {32'd0, nv_a};
      1: return b ? {32'd0, ni_b} : {32'd0, ni_a};
      2: return b ? va_b : va_a;
      3: return b ? ia_b : ia_a;
      4: return b ? w0_b : w0_a;
      5: return b ? w1_b : w1_a;
      default: return b ? {32'd0, nr_b} : {32'd0, nr_a};
    endcase
  endfunction

  function automatic logic [417:0] snap(input bit b);
    if (b) return {rb_v, rb_d, nv_b, ni_b, va_b, ia_b, w0_b, w1_b, nr_b, st_b};
    return {ra_v, ra_d, nv_a, ni_a, va_a, ia_a, w0_a, w1_a, nr_a, st_a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input int a, input logic [63:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = 32'(a);
    req_data  = d;
    step();
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_data  = '0;
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    if (m_phase == 0) begin
      if (a >= 0 && a < 7) m_reg[a] = narrow(a) ? {32'd0, d[31:0]} : d;
      else if (a == A_DRP) m_phase = 1;
    end else if (a >= 0 && a <= A_DONE_ALL) begin
      m_err = 1'b1;
    end
    req(1'b1, a, d);
  endtask

  task automatic rd(input int a);
    req(1'b0, a, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    core_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    foreach (m_reg[i]) m_reg[i] = '0;
    m_err = 1'b0;
    m_phase = 0;
  endtask

  task automatic configure_spec();
    wr(A_N_VERT, 64'd10);
    wr(A_N_INEDGES, 64'd32);
    wr(A_VADDR, 64'd0);
    wr(A_IEADDR, 64'd160);
    wr(A_WA0, 64'd416);
    wr(A_WA1, 64'd496);
    wr(A_N_ROUNDS, 64'd10);
    wr(A_DRP, {$urandom, $urandom});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_total++;
    if (snap(0) !== '0 || snap(1) !== '0) $display("FAIL reset_outputs a=%h b=%h required all zero", snap(0), snap(1));
    else n_pass++;
    do_reset();
  endtask

  task automatic test_config();
    bit early;
    logic [63:0] v [7];
    do_reset();
    v = '{64'd10, 64'd32, 64'd0, 64'd160, 64'd416, 64'd496, 64'd10};
    early = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr(i, v[i]);
      if (st_a || st_b) early = 1'b1;
    end
    n_total++;
    if (early !== 1'b0) $display("FAIL start_early got 1 required 0");
    else n_pass++;
    wr(A_DRP, {$urandom, $urandom});
    n_total++;
    if ({st_a, st_b} !== 2'b11) $display("FAIL start_pulse got %b required 11", {st_a, st_b});
    else n_pass++;
    step();
    n_total++;
    if ({st_a, st_b} !== 2'b00) $display("FAIL start_width got %b required 00", {st_a, st_b});
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (outv(0, i) !== v[i] || outv(1, i) !== v[i])
        $display("FAIL param_out[%0d] a=%0d b=%0d required %0d", i, outv(0, i), outv(1, i), v[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_params();
    int idx;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 7; i++) wr(i, {$urandom, $urandom});
      wr(A_DRP, {$urandom, $urandom});
      for (int k = 0; k < 7; k++) begin
        idx = $urandom_range(0, 6);
        rd(idx);
        n_total++;
        if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, m_reg[idx], 1'b1, m_reg[idx]})
          $display("FAIL rand_read[%0d] a=%b/%h b=%b/%h required 1/%h", idx, ra_v, ra_d, rb_v, rb_d, m_reg[idx]);
        else n_pass++;
      end
      for (int i = 0; i < 7; i++) begin
        n_total++;
        if (outv(0, i) !== m_reg[i] || outv(1, i) !== m_reg[i])
          $display("FAIL rand_out[%0d] a=%h b=%h required %h", i, outv(0, i), outv(1, i), m_reg[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_read_regs();
    do_reset();
    wr(A_IEADDR, 64'd160);
    rd(A_IEADDR);
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd160, 1'b1, 64'd160})
      $display("FAIL read_ieaddr a=%b/%0d b=%b/%0d required 1/160", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
    rd(A_UNKNOWN);
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd0, 1'b1, 64'd0})
      $display("FAIL read_unknown a=%b/%0d b=%b/%0d required 1/0", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
  endtask

  task automatic test_done_wait();
    bit seen;
    int n;
    do_reset();
    configure_spec();
    rd(A_DONE_ALL);
    n = 20 + $urandom_range(0, 10);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (ra_v || rb_v) seen = 1'b1;
      step();
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL done_wait_early got response required none");
    else n_pass++;
    core_done = 1'b1;
    step();
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd1, 1'b1, 64'd1})
      $display("FAIL done_wait_resp a=%b/%0d b=%b/%0d required 1/1", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
    step();
    n_total++;
    if ({ra_v, rb_v} !== 2'b00) $display("FAIL done_wait_once got %b required 00", {ra_v, rb_v});
    else n_pass++;
    core_done = 1'b0;
    rd(A_DONE_ALL);
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd1, 1'b1, 64'd1})
      $display("FAIL done_state_read a=%b/%0d b=%b/%0d required 1/1", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
  endtask

  task automatic test_err();
    logic [63:0] exp;
    do_reset();
    configure_spec();
    wr(A_N_VERT, 64'd99);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    rd(A_DONE_ALL);
    exp = m_err ? 64'd0 : 64'd1;
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, exp, 1'b1, exp})
      $display("FAIL run_write_err a=%b/%0d b=%b/%0d required 1/%0d", ra_v, ra_d, rb_v, rb_d, exp);
    else n_pass++;
    n_total++;
    if (nv_a !== m_reg[0][31:0] || nv_b !== m_reg[0][31:0])
      $display("FAIL run_write_blocked a=%0d b=%0d required %0d", nv_a, nv_b, m_reg[0][31:0]);
    else n_pass++;
  endtask

  task automatic test_unknown_write();
    do_reset();
    wr(A_UNKNOWN, {$urandom, $urandom});
    configure_spec();
    wr(A_UNKNOWN, {$urandom, $urandom});
    core_done = 1'b1;
    rd(A_DONE_ALL);
    core_done = 1'b0;
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd1, 1'b1, 64'd1})
      $display("FAIL unknown_write_no_err a=%b/%0d b=%b/%0d required 1/1", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
  endtask

  task automatic test_pending_drop();
    do_reset();
    configure_spec();
    rd(A_DONE_ALL);
    repeat (3) step();
    m_err = 1'b1;
    rd(A_N_VERT);
    n_total++;
    if ({ra_v, rb_v} !== 2'b00) $display("FAIL pending_read_dropped got %b required 00", {ra_v, rb_v});
    else n_pass++;
    req(1'b1, A_N_VERT, 64'd77);
    step();
    n_total++;
    if (nv_a !== 32'd10 || nv_b !== 32'd10) $display("FAIL pending_write_dropped a=%0d b=%0d required 10", nv_a, nv_b);
    else n_pass++;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd0, 1'b1, 64'd0})
      $display("FAIL pending_drop_status a=%b/%0d b=%b/%0d required 1/0", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
  endtask

  task automatic test_config_ignores_done();
    bit seen;
    do_reset();
    core_done = 1'b1;
    rd(A_DONE_ALL);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ra_v || rb_v) seen = 1'b1;
      step();
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL config_done_ignored got response required none");
    else n_pass++;
    core_done = 1'b0;
    do_reset();
  endtask

  task automatic test_timeout();
    int  k_b;
    bit  seen_a;
    logic [63:0] d_b;
    do_reset();
    configure_spec();
    rd(A_DONE_ALL);
    k_b = -1;
    d_b = 64'hX;
    seen_a = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (rb_v && k_b < 0) begin
        k_b = k;
        d_b = rb_d;
      end
      if (ra_v) seen_a = 1'b1;
      step();
    end
    n_total++;
    if (k_b !== 50 || d_b !== 64'd0) $display("FAIL timeout_resp cycle=%0d data=%h required cycle 50 data 0", k_b, d_b);
    else n_pass++;
    n_total++;
    if (seen_a !== 1'b0) $display("FAIL no_timeout_wait got response required none");
    else n_pass++;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    n_total++;
    if ({ra_v, ra_d, rb_v} !== {1'b1, 64'd1, 1'b0})
      $display("FAIL timeout_then_done a=%b/%0d b=%b required a 1/1 b 0", ra_v, ra_d, rb_v);
    else n_pass++;
    rd(A_DONE_ALL);
    n_total++;
    if ({ra_v, ra_d, rb_v, rb_d} !== {1'b1, 64'd1, 1'b1, 64'd1})
      $display("FAIL timeout_no_err a=%b/%0d b=%b/%0d required 1/1", ra_v, ra_d, rb_v, rb_d);
    else n_pass++;
  endtask

  task automatic test_reset_pending();
    bit seen;
    do_reset();
    configure_spec();
    rd(A_DONE_ALL);
    repeat ($urandom_range(2, 20)) step();
    rst = 1'b1;
    #2;
    n_total++;
    if (snap(0) !== '0 || snap(1) !== '0) $display("FAIL async_reset a=%h b=%h required all zero", snap(0), snap(1));
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    foreach (m_reg[i]) m_reg[i] = '0;
    m_err = 1'b0;
    m_phase = 0;
    core_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ra_v || rb_v) seen = 1'b1;
    end
    core_done = 1'b0;
    n_total++;
    if (seen !== 1'b0) $display("FAIL reset_drops_pending got response required none");
    else n_pass++;
    wr(A_N_VERT, 64'd5);
    wr(A_DRP, 64'd0);
    n_total++;
    if ({nv_a, nv_b, st_a, st_b} !== {32'd5, 32'd5, 2'b11})
      $display("FAIL reset_back_to_config nv=%0d/%0d start=%b%b required 5/5 start 11", nv_a, nv_b, st_a, st_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_config();
    test_random_params();
    test_read_regs();
    test_done_wait();
    test_err();
    test_unknown_write();
    test_pending_drop();
    test_config_ignores_done();
    test_timeout();
    test_reset_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
